// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frames a stream of complex samples for an external 8-point, 3-stage FFT
//   datapath. Eight input samples are collected, the packed frame is held on
//   dp_in while the datapath works for LAT cycles, the result is captured
//   into an output buffer and then streamed out in natural order.
//
// Parameters
//   N    sample component width W = 2**N bits (two's complement)
//   LAT  datapath latency in cycles, 1..15
//
// Build option
//   FFT_FRAME_CTRL_BITREV_EN  defined: input samples are written in 3-bit
//                             bit-reversed slot order (DIT datapath).
//                             undefined: natural slot order.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   s_valid/s_ready       input sample handshake
//   s_re, s_im            input sample
//   dp_in                 packed frame to datapath (slot k: re at [2kW+:W],
//                         im at [(2k+1)W+:W])
//   dp_res                packed datapath result, same layout
//   m_valid/m_ready       output sample handshake
//   m_re, m_im, m_last    output sample, m_last on the 8th of a frame
//   frame_cnt             completed frames, wraps 255 -> 0
//
// state    | meaning
// ---------+---------------------------------------------------------
// LOAD     | accept 8 samples into the input buffer
// RUN      | hold dp_in, wait LAT cycles, capture dp_res
// DRAIN    | stream the 8 captured results downstream

module fft_frame_ctrl #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2**N-1:0]     s_re,
  input  logic [2**N-1:0]     s_im,
  output logic [16*2**N-1:0]  dp_in,
  input  logic [16*2**N-1:0]  dp_res,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2**N-1:0]     m_re,
  output logic [2**N-1:0]     m_im,
  output logic                m_last,
  output logic [7:0]          frame_cnt
);

  localparam int W = 2**N;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [3:0]   wait_q, wait_d;
  logic [2:0]   rd_q, rd_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;

  logic [W-1:0] in_re_q  [8];
  logic [W-1:0] in_im_q  [8];
  logic [W-1:0] out_re_q [8];
  logic [W-1:0] out_im_q [8];

  logic         load_acc;
  logic         run_done;
  logic [2:0]   wr_slot;

  // Slot mapping for the write side; the read side is always natural order.
  function automatic logic [2:0] wr_idx(input logic [2:0] c);
`ifdef FFT_FRAME_CTRL_BITREV_EN
    return {c[0], c[1], c[2]};
`else
    return c;
`endif
  endfunction

  assign load_acc = (state_q == ST_LOAD) && s_valid;
  assign run_done = (state_q == ST_RUN) && (wait_q == WAIT_LAST);
  assign wr_slot  = wr_idx(cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    rd_d        = rd_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          cnt_d = cnt_q + 3'd1;             // wraps 7 -> 0 on the last accept
          if (cnt_q == 3'd7) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 4'd0;
          state_d = ST_DRAIN;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          rd_d = rd_q + 3'd1;
          if (rd_q == 3'd7) begin
            state_d     = ST_LOAD;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = 3'd0;
        wait_d  = 4'd0;
        rd_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= 3'd0;
      wait_q      <= 4'd0;
      rd_q        <= 3'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        in_re_q[k]  <= '0;
        in_im_q[k]  <= '0;
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      if (load_acc) begin
        in_re_q[wr_slot] <= s_re;
        in_im_q[wr_slot] <= s_im;
      end
      if (run_done) begin
        for (int k = 0; k < 8; k++) begin
          out_re_q[k] <= dp_res[2*k*W +: W];
          out_im_q[k] <= dp_res[(2*k+1)*W +: W];
        end
      end
    end
  end

  always_comb begin
    dp_in = '0;
    for (int k = 0; k < 8; k++) begin
      dp_in[2*k*W +: W]     = in_re_q[k];
      dp_in[(2*k+1)*W +: W] = in_im_q[k];
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign m_valid   = (state_q == ST_DRAIN);
  assign m_last    = m_valid && (rd_q == 3'd7);
  assign m_re      = m_valid ? out_re_q[rd_q] : '0;
  assign m_im      = m_valid ? out_im_q[rd_q] : '0;
  assign frame_cnt = frame_cnt_q;

endmodule
